rca_result_collector: RTL and testbench

Downstream stage of the 32-bit time-multiplexed ripple-carry adder. The adder presents one 16-bit half-sum plus carry per transfer, selected by its half-select flag. This block collects the LSB half and then the MSB half, reassembles a 32-bit sum with final carry, and offers it on a ready/valid output. It also supports a 16-bit-only mode for when the MSB domain is powered down, flags out-of-order halves, and counts delivered results.

---
 rtl/rca_pkg.sv | 17 +
 rtl/rca_result_collector.sv | 122 ++++++++++++
 tb/tb_rca_result_collector.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry adder result collector:
// FSM state encoding, default widths and half-select flag values.
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MSB = 2'd1,
    HOLD     = 2'd2
  } state_e;

  localparam int HALF_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;

  localparam logic FLAG_LSB = 1'b0;
  localparam logic FLAG_MSB = 1'b1;

endpackage : rca_pkg

// File: rtl/rca_result_collector.sv
// Collects the LSB and MSB half-sums from the time-multiplexed adder,
// reassembles the full sum with final carry, and offers it on ready/valid.
module rca_result_collector
  import rca_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [HALF_W-1:0]   S_half,
  input  logic                C_half,
  input  logic                flag,
  input  logic                mode16,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*HALF_W-1:0] SUM,
  output logic                C_out,
  output logic                seq_err,
  output logic [CNT_W-1:0]    result_cnt
);

  state_e              state_q, state_d;
  logic [2*HALF_W-1:0] sum_q, sum_d;
  logic                c_out_q, c_out_d;
  logic                seq_err_q, seq_err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic in_fire;
  logic lsb_accept;
  logic msb_accept;
  logic deliver;

  // in_ready is a pure decode of state_q, so in_fire never depends on itself.
  assign in_fire    = in_valid && in_ready;
  assign lsb_accept = in_fire && (flag == FLAG_LSB);
  assign msb_accept = in_fire && (flag == FLAG_MSB) && (state_q == WAIT_MSB);
  assign deliver    = (state_q == HOLD) && out_ready;

  // State register and datapath registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      sum_q     <= '0;
      c_out_q   <= 1'b0;
      seq_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      c_out_q   <= c_out_d;
      seq_err_q <= seq_err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, WAIT_MSB: begin
        if (lsb_accept) begin
          state_d = mode16 ? HOLD : WAIT_MSB;
        end else if (msb_accept) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: the LSB half always restarts a result, so a second
  // LSB in WAIT_MSB simply overwrites the first.
  always_comb begin
    sum_d     = sum_q;
    c_out_d   = c_out_q;
    seq_err_d = 1'b0;
    cnt_d     = cnt_q;

    if (lsb_accept) begin
      sum_d[HALF_W-1:0] = S_half;
      if (mode16) begin
        sum_d[2*HALF_W-1:HALF_W] = '0;
        c_out_d                  = C_half;
      end
      seq_err_d = (state_q == WAIT_MSB);
    end else if (msb_accept) begin
      sum_d[2*HALF_W-1:HALF_W] = S_half;
      c_out_d                  = C_half;
    end else if (in_fire) begin
      // MSB half arriving in IDLE: data dropped, flagged.
      seq_err_d = 1'b1;
    end

    if (deliver) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output decode: all outputs come from registers only.
  always_comb begin
    in_ready  = (state_q != HOLD);
    out_valid = (state_q == HOLD);
  end

  assign SUM        = sum_q;
  assign C_out      = c_out_q;
  assign seq_err    = seq_err_q;
  assign result_cnt = cnt_q;

endmodule : rca_result_collector

// File: tb/tb_rca_result_collector.sv
// Self-checking bench: directed vector table with hand-derived expectations,
// randomized traffic against a transaction-level model, and a counter-wrap run.
module tb_rca_result_collector;

  localparam int HALF_W = 16;
  localparam int CNT_W  = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic              in_valid;
  logic              in_ready;
  logic [HALF_W-1:0] S_half;
  logic              C_half;
  logic              flag;
  logic              mode16;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       SUM;
  logic              C_out;
  logic              seq_err;
  logic [CNT_W-1:0]  result_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  rca_result_collector #(.HALF_W(HALF_W), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .S_half     (S_half),
    .C_half     (C_half),
    .flag       (flag),
    .mode16     (mode16),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .SUM        (SUM),
    .C_out      (C_out),
    .seq_err    (seq_err),
    .result_cnt (result_cnt)
  );

  always #5 CLK = ~CLK;

  // Reference model: tracks whether an LSB is pending and whether a finished
  // result is parked at the output, in terms of transfers and deliveries.
  bit          m_lsb_pending;
  bit          m_holding;
  logic [15:0] m_lo, m_hi;
  bit          m_c;
  bit          m_err;
  int          m_count;

  task automatic model_update(input bit rst, input bit v, input logic [15:0] s,
                              input bit c, input bit f, input bit m, input bit ordy);
    m_err = 1'b0;
    if (rst) begin
      m_lsb_pending = 1'b0; m_holding = 1'b0;
      m_lo = '0; m_hi = '0; m_c = 1'b0; m_count = 0;
    end else if (m_holding) begin
      if (ordy) begin
        m_holding = 1'b0;
        m_count   = (m_count + 1) % (1 << CNT_W);
      end
    end else if (v) begin
      if (!f) begin
        m_err = m_lsb_pending;
        m_lo  = s;
        if (m) begin
          m_hi = '0; m_c = c; m_holding = 1'b1; m_lsb_pending = 1'b0;
        end else begin
          m_lsb_pending = 1'b1;
        end
      end else if (m_lsb_pending) begin
        m_hi = s; m_c = c; m_holding = 1'b1; m_lsb_pending = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Drive inputs, take one rising edge, advance the model, sample 1 ns later.
  task automatic step(input bit rst, input bit v, input logic [15:0] s,
                      input bit c, input bit f, input bit m, input bit ordy);
    RST = rst; in_valid = v; S_half = s; C_half = c; flag = f; mode16 = m; out_ready = ordy;
    @(posedge CLK);
    model_update(rst, v, s, c, f, m, ordy);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".in_ready"},  64'(in_ready),   64'(!m_holding));
    check({tag, ".out_valid"}, 64'(out_valid),  64'(m_holding));
    check({tag, ".sum"},       64'(SUM),        64'({m_hi, m_lo}));
    check({tag, ".c_out"},     64'(C_out),      64'(m_c));
    check({tag, ".seq_err"},   64'(seq_err),    64'(m_err));
    check({tag, ".cnt"},       64'(result_cnt), 64'(m_count));
  endtask

  typedef struct {
    bit          rst, v;
    logic [15:0] s;
    bit          c, f, m, ordy;
    bit          e_ir, e_ov;
    logic [31:0] e_sum;
    bit          e_c, e_err;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[22];

  initial begin
    //          rst v  S         C  F  M  OR   ir ov sum            c  err cnt
    vecs[0]  = '{1, 0, 16'h0000, 0, 0, 0, 0,   1, 0, 32'h0000_0000, 0, 0, 0};
    vecs[1]  = '{0, 1, 16'h5678, 1, 0, 0, 1,   1, 0, 32'h0000_5678, 0, 0, 0};
    vecs[2]  = '{0, 1, 16'h1234, 0, 1, 0, 1,   0, 1, 32'h1234_5678, 0, 0, 0};
    vecs[3]  = '{0, 0, 16'h0000, 0, 0, 0, 1,   1, 0, 32'h1234_5678, 0, 0, 1};
    vecs[4]  = '{0, 1, 16'hFFFF, 1, 0, 1, 1,   0, 1, 32'h0000_FFFF, 1, 0, 1};
    vecs[5]  = '{0, 1, 16'hAAAA, 0, 1, 0, 0,   0, 1, 32'h0000_FFFF, 1, 0, 1};
    vecs[6]  = '{0, 1, 16'hBBBB, 0, 0, 1, 0,   0, 1, 32'h0000_FFFF, 1, 0, 1};
    vecs[7]  = '{0, 1, 16'hCCCC, 0, 1, 0, 0,   0, 1, 32'h0000_FFFF, 1, 0, 1};
    vecs[8]  = '{0, 1, 16'hDDDD, 0, 0, 0, 0,   0, 1, 32'h0000_FFFF, 1, 0, 1};
    vecs[9]  = '{0, 1, 16'hEEEE, 0, 1, 1, 0,   0, 1, 32'h0000_FFFF, 1, 0, 1};
    vecs[10] = '{0, 0, 16'h0000, 0, 0, 0, 1,   1, 0, 32'h0000_FFFF, 1, 0, 2};
    vecs[11] = '{0, 1, 16'hBEEF, 1, 1, 0, 1,   1, 0, 32'h0000_FFFF, 1, 1, 2};
    vecs[12] = '{0, 0, 16'h0000, 0, 0, 0, 1,   1, 0, 32'h0000_FFFF, 1, 0, 2};
    vecs[13] = '{0, 1, 16'h0001, 0, 0, 0, 1,   1, 0, 32'h0000_0001, 1, 0, 2};
    vecs[14] = '{0, 1, 16'h0002, 0, 0, 0, 1,   1, 0, 32'h0000_0002, 1, 1, 2};
    vecs[15] = '{0, 1, 16'h0003, 0, 1, 0, 1,   0, 1, 32'h0003_0002, 0, 0, 2};
    vecs[16] = '{0, 0, 16'h0000, 0, 0, 0, 1,   1, 0, 32'h0003_0002, 0, 0, 3};
    vecs[17] = '{0, 1, 16'h1111, 0, 0, 0, 1,   1, 0, 32'h0003_1111, 0, 0, 3};
    vecs[18] = '{1, 0, 16'h0000, 0, 0, 0, 1,   1, 0, 32'h0000_0000, 0, 0, 0};
    vecs[19] = '{0, 1, 16'h2222, 1, 0, 1, 0,   0, 1, 32'h0000_2222, 1, 0, 0};
    vecs[20] = '{1, 0, 16'h0000, 0, 0, 0, 1,   1, 0, 32'h0000_0000, 0, 0, 0};
    vecs[21] = '{0, 0, 16'h9999, 1, 0, 1, 1,   1, 0, 32'h0000_0000, 0, 0, 0};

    // Directed table: hand-derived expectations, model kept in lock-step.
    for (int i = 0; i < 22; i++) begin
      step(vecs[i].rst, vecs[i].v, vecs[i].s, vecs[i].c, vecs[i].f, vecs[i].m, vecs[i].ordy);
      check($sformatf("vec%0d.in_ready", i),  64'(in_ready),   64'(vecs[i].e_ir));
      check($sformatf("vec%0d.out_valid", i), 64'(out_valid),  64'(vecs[i].e_ov));
      check($sformatf("vec%0d.sum", i),       64'(SUM),        64'(vecs[i].e_sum));
      check($sformatf("vec%0d.c_out", i),     64'(C_out),      64'(vecs[i].e_c));
      check($sformatf("vec%0d.seq_err", i),   64'(seq_err),    64'(vecs[i].e_err));
      check($sformatf("vec%0d.cnt", i),       64'(result_cnt), 64'(vecs[i].e_cnt));
    end

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           16'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
      check_model($sformatf("rnd%0d", i));
    end

    // Counter wrap: 17 mode16 deliveries on a 4-bit counter end at 1.
    step(1, 0, 16'h0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      step(0, 1, 16'($urandom), 1'($urandom), 0, 1, 1);
      check_model($sformatf("wrap%0d.acc", i));
      step(0, 0, 16'h0, 0, 0, 0, 1);
      check_model($sformatf("wrap%0d.dlv", i));
    end
    check("wrap.final_cnt", 64'(result_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_rca_result_collector
